pipe_hazard_ctrl: RTL and testbench

// Central hazard/stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and forwarding controller for a 5-stage in-order pipeline.
// Tracks a destination scoreboard for EX/MEM/WB and sequences halt drain and memory stalls.
module pipe_hazard_ctrl #(
  parameter int REG_BITS = 3,
  parameter int FWD_EN   = 1,
  parameter int TMO_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_vld,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic                id_rs_used,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rt_used,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_halt,
  input  logic                mem_redirect,
  input  logic                mem_busy,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                if_id_flush,
  output logic                id_ex_en,
  output logic                id_ex_flush,
  output logic                ex_mem_en,
  output logic                ex_mem_flush,
  output logic                mem_wb_en,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                halted,
  output logic                err
);

  typedef struct packed {
    logic                vld;
    logic [REG_BITS-1:0] rd;
    logic                rw;
    logic                mr;
    logic                halt;
  } slot_t;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT_ST = 2'd2} state_t;

  localparam bit                  FWD_ON  = (FWD_EN != 32'sd0);
  localparam logic [TMO_BITS-1:0] WD_MAX  = {TMO_BITS{1'b1}};
  localparam logic [TMO_BITS-1:0] WD_LAST = {{(TMO_BITS-1){1'b1}}, 1'b0};
  localparam logic [TMO_BITS-1:0] WD_ONE  = {{(TMO_BITS-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  slot_t               ex_slot, mem_slot, wb_slot, id_slot;
  logic [TMO_BITS-1:0] wd;
  logic                hit_ex, hit_mem, hit_wb, load_use, advance, redirect, bubble;
  logic [1:0]          fa_nxt, fb_nxt;

  function automatic logic src_hit(input slot_t s, input logic [REG_BITS-1:0] src, input logic used);
    return used & s.vld & s.rw & (s.rd == src);
  endfunction

  // Newest producer wins: EX slot result before MEM slot write data.
  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                         input logic [REG_BITS-1:0] src, input logic used);
    logic [1:0] sel;
    if (src_hit(ex, src, used)) begin
      sel = 2'd1;
    end else if (src_hit(mem, src, used)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // RAW detection against the scoreboard and the ID/EX load decision.
  always_comb begin
    id_slot  = {id_vld, id_rd, id_reg_write, id_mem_read, id_halt};
    hit_ex   = src_hit(ex_slot, id_rs, id_rs_used) | src_hit(ex_slot, id_rt, id_rt_used);
    hit_mem  = src_hit(mem_slot, id_rs, id_rs_used) | src_hit(mem_slot, id_rt, id_rt_used);
    hit_wb   = src_hit(wb_slot, id_rs, id_rs_used) | src_hit(wb_slot, id_rt, id_rt_used);
    if (FWD_ON) begin
      load_use = id_vld & hit_ex & ex_slot.mr;
      fa_nxt   = fwd_sel(ex_slot, mem_slot, id_rs, id_rs_used);
      fb_nxt   = fwd_sel(ex_slot, mem_slot, id_rt, id_rt_used);
    end else begin
      load_use = id_vld & (hit_ex | hit_mem | hit_wb);
      fa_nxt   = 2'd0;
      fb_nxt   = 2'd0;
    end
    advance  = ~mem_busy & (state != HALT_ST);
    redirect = advance & mem_redirect;
    bubble   = mem_redirect | load_use | ~id_vld;
  end

  // Stage enables, flushes and next FSM state.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b0;
    state_nxt    = state;
    if (advance) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else begin
        id_ex_flush = 1'b0;
      end
      // While draining, fetch stops and IF/ID keeps loading NOPs.
      if ((state == DRAIN) && !redirect) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        if_id_flush = if_id_flush;
      end
      case (state)
        RUN: begin
          if (!bubble && id_halt) state_nxt = DRAIN;
          else                    state_nxt = RUN;
        end
        DRAIN: begin
          if (wb_slot.vld && wb_slot.halt)                     state_nxt = HALT_ST;
          else if (redirect && !(mem_slot.vld && mem_slot.halt)) state_nxt = RUN;
          else                                                 state_nxt = DRAIN;
        end
        default: state_nxt = state;
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Scoreboard shift, forward-select registers, watchdog and FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      fwd_a_sel <= 2'd0;
      fwd_b_sel <= 2'd0;
      wd        <= '0;
      err       <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALT_ST);
      if (mem_busy) begin
        if (wd != WD_MAX) wd <= wd + WD_ONE;
        if (wd >= WD_LAST) err <= 1'b1;
      end else begin
        wd <= '0;
      end
      if (advance) begin
        wb_slot   <= mem_slot;
        mem_slot  <= redirect ? '0 : ex_slot;
        ex_slot   <= bubble ? '0 : id_slot;
        fwd_a_sel <= bubble ? 2'd0 : fa_nxt;
        fwd_b_sel <= bubble ? 2'd0 : fb_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a pipeline-occupancy model checks every cycle,
// hand-computed literal expectations pin load-use, forwarding, redirect, busy, halt and reset.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic id_vld = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0, id_reg_write = 1'b0;
  logic id_mem_read = 1'b0, id_halt = 1'b0, mem_redirect = 1'b0, mem_busy = 1'b0;
  logic [2:0] id_rs = 3'd0, id_rt = 3'd0, id_rd = 3'd0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic halted, err;
  logic d0_pc_en, d0_if_id_en, d0_if_id_flush, d0_id_ex_en, d0_id_ex_flush;
  logic d0_ex_mem_en, d0_ex_mem_flush, d0_mem_wb_en, d0_halted, d0_err;
  logic [1:0] d0_fwd_a_sel, d0_fwd_b_sel;

  int checks = 0, errors = 0, n;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_BITS(3), .FWD_EN(1), .TMO_BITS(4)) dut (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_halt(id_halt), .mem_redirect(mem_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted), .err(err));

  pipe_hazard_ctrl #(.REG_BITS(3), .FWD_EN(0), .TMO_BITS(4)) dut0 (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_halt(id_halt), .mem_redirect(mem_redirect), .mem_busy(mem_busy),
    .pc_en(d0_pc_en), .if_id_en(d0_if_id_en), .if_id_flush(d0_if_id_flush), .id_ex_en(d0_id_ex_en),
    .id_ex_flush(d0_id_ex_flush), .ex_mem_en(d0_ex_mem_en), .ex_mem_flush(d0_ex_mem_flush),
    .mem_wb_en(d0_mem_wb_en), .fwd_a_sel(d0_fwd_a_sel), .fwd_b_sel(d0_fwd_b_sel),
    .halted(d0_halted), .err(d0_err));

  // Model of the FWD_EN=1 instance: which instruction occupies EX, MEM, WB.
  typedef struct packed { bit vld; bit [2:0] rd; bit rw; bit mr; bit halt; } ins_t;
  ins_t pipe[3];
  int   mode;       // 0 running, 1 draining, 2 halted
  int   busy_run;   // consecutive busy cycles so far
  bit   m_err;
  int   m_fa, m_fb;

  function automatic bit reads(input ins_t p);
    return p.vld && p.rw && id_vld &&
           ((id_rs_used && p.rd == id_rs) || (id_rt_used && p.rd == id_rt));
  endfunction
  function automatic bit m_live();  return mode != 2 && !mem_busy; endfunction
  function automatic bit m_redir(); return m_live() && mem_redirect; endfunction
  function automatic bit m_lu();    return reads(pipe[0]) && pipe[0].mr; endfunction
  function automatic bit m_st();    return m_live() && !m_redir() && m_lu(); endfunction
  function automatic bit m_bub();   return mem_redirect || m_lu() || !id_vld; endfunction
  function automatic int src_sel(input bit used, input bit [2:0] r);
    for (int k = 0; k < 2; k++)
      if (used && pipe[k].vld && pipe[k].rw && pipe[k].rd == r) return k + 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode <= 0; busy_run <= 0; m_err <= 1'b0; m_fa <= 0; m_fb <= 0;
      for (int k = 0; k < 3; k++) pipe[k] <= '0;
    end else begin
      busy_run <= mem_busy ? busy_run + 1 : 0;
      if (mem_busy && busy_run + 1 >= 15) m_err <= 1'b1;
      if (m_live()) begin
        if (mode == 1 && pipe[2].vld && pipe[2].halt) mode <= 2;
        else if (mode == 1 && mem_redirect && !(pipe[1].vld && pipe[1].halt)) mode <= 0;
        else if (mode == 0 && !m_bub() && id_halt) mode <= 1;
        m_fa <= m_bub() ? 0 : src_sel(id_rs_used, id_rs);
        m_fb <= m_bub() ? 0 : src_sel(id_rt_used, id_rt);
        pipe[2] <= pipe[1];
        pipe[1] <= mem_redirect ? '0 : pipe[0];
        pipe[0] <= m_bub() ? '0 : {1'b1, id_rd, id_reg_write, id_mem_read, id_halt};
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && cmp_on) begin
      chk("m_pc_en",     pc_en,       m_live() && (m_redir() || (!m_st() && mode != 1)));
      chk("m_if_id_en",  if_id_en,    m_live() && (m_redir() || mode == 1 || !m_st()));
      chk("m_if_id_fl",  if_id_flush, m_live() && (m_redir() || mode == 1));
      chk("m_id_ex_en",  id_ex_en,    m_live());
      chk("m_id_ex_fl",  id_ex_flush, m_redir() || m_st());
      chk("m_ex_mem_en", ex_mem_en,   m_live());
      chk("m_ex_mem_fl", ex_mem_flush, m_redir());
      chk("m_mem_wb_en", mem_wb_en,   m_live());
      chk("m_fwd_a",     fwd_a_sel,   m_fa);
      chk("m_fwd_b",     fwd_b_sel,   m_fb);
      chk("m_halted",    halted,      mode == 2);
      chk("m_err",       err,         m_err);
    end
  end

  task automatic set_id(input bit v, input bit [2:0] rs, input bit rsu, input bit [2:0] rt,
                        input bit rtu, input bit [2:0] rd, input bit rw, input bit mr, input bit ht);
    id_vld = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_halt = ht;
  endtask
  task automatic nop();  set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic step(); @(posedge clk); #1; endtask
  task automatic look(); #1; endtask
  task automatic drain3(); nop(); step(); step(); step(); endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", fwd_a_sel, 0); chk("rst_halted", halted, 0); chk("rst_err", err, 0);
    rst = 1'b1; cmp_on = 1'b1;
    look();
    chk("rst_pc_en", pc_en, 1); chk("rst_id_ex_en", id_ex_en, 1); chk("rst_if_id_fl", if_id_flush, 0);
    step();

    // load-use: LD r1 ; ADD r2,r1,r3
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0); look(); chk("ld_pc_en", pc_en, 1); step();
    set_id(1, 1, 1, 3, 1, 2, 1, 0, 0); look();
    chk("lu_pc_en", pc_en, 0); chk("lu_id_ex_fl", id_ex_flush, 1); chk("lu_if_id_en", if_id_en, 0);
    step(); look();
    chk("lu_pc_en2", pc_en, 1); chk("lu_id_ex_fl2", id_ex_flush, 0);
    step(); nop(); look();
    chk("lu_fwd_a", fwd_a_sel, 2); chk("lu_fwd_b", fwd_b_sel, 0);
    drain3();

    // ADD r1 ; SUB r4,r1,r1 forwards from EX/MEM with no stall
    set_id(1, 2, 1, 3, 1, 1, 1, 0, 0); step();
    set_id(1, 1, 1, 1, 1, 4, 1, 0, 0); look(); chk("fw_pc_en", pc_en, 1); step();
    nop(); look(); chk("fw_a", fwd_a_sel, 1); chk("fw_b", fwd_b_sel, 1);
    drain3();

    // redirect overrides a pending load-use
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); step();
    set_id(1, 5, 1, 0, 0, 6, 1, 0, 0); mem_redirect = 1'b1; look();
    chk("rd_pc_en", pc_en, 1); chk("rd_if_id_fl", if_id_flush, 1);
    chk("rd_id_ex_fl", id_ex_flush, 1); chk("rd_ex_mem_fl", ex_mem_flush, 1);
    step(); mem_redirect = 1'b0; look(); chk("rd_no_stall", pc_en, 1);
    step(); nop(); look(); chk("rd_mem_slot_gone", fwd_a_sel, 0);
    drain3();

    // busy beats load-use, stall re-evaluated after release
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    set_id(1, 1, 1, 0, 0, 2, 1, 0, 0); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("bz_pc_en", pc_en, 0); chk("bz_id_ex_en", id_ex_en, 0);
      chk("bz_mem_wb_en", mem_wb_en, 0); chk("bz_id_ex_fl", id_ex_flush, 0);
      step();
    end
    mem_busy = 1'b0; look(); chk("bz_err", err, 0); chk("bz_then_stall", id_ex_flush, 1);
    step(); look(); chk("bz_resume", pc_en, 1);
    drain3();

    // watchdog: 14 busy cycles tolerated, the 15th sets sticky err
    mem_busy = 1'b1;
    for (int i = 0; i < 14; i++) step();
    look(); chk("wd_err14", err, 0);
    step(); look(); chk("wd_err15", err, 1);
    mem_busy = 1'b0; step(); look(); chk("wd_sticky", err, 1);

    // async reset while stalled on busy with live forward selects
    set_id(1, 2, 1, 3, 1, 1, 1, 0, 0); step();
    set_id(1, 1, 1, 1, 1, 4, 1, 0, 0); step();
    nop(); mem_busy = 1'b1; look(); chk("ar_pre_fwd", fwd_a_sel, 1);
    step(); look(); rst = 1'b0; #1;
    chk("ar_fwd_a", fwd_a_sel, 0); chk("ar_fwd_b", fwd_b_sel, 0);
    chk("ar_err", err, 0); chk("ar_halted", halted, 0);
    mem_busy = 1'b0; #1; chk("ar_pc_en", pc_en, 1);
    @(negedge clk); #1; rst = 1'b1;
    step();

    // redirect kills a draining halt still in EX
    set_id(1, 0, 0, 0, 0, 2, 1, 0, 0); step();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
    nop(); mem_redirect = 1'b1; look();
    chk("dr_pc_en", pc_en, 1); chk("dr_ex_mem_fl", ex_mem_flush, 1);
    step(); mem_redirect = 1'b0; look();
    chk("dr_run_pc_en", pc_en, 1); chk("dr_if_id_fl", if_id_flush, 0);
    drain3();

    // halt drain
    set_id(1, 0, 0, 0, 0, 2, 1, 0, 0); step();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
    nop(); look();
    chk("hl_pc_en", pc_en, 0); chk("hl_if_id_fl", if_id_flush, 1); chk("hl_mem_wb_en", mem_wb_en, 1);
    n = 1;
    while (!halted && n < 10) begin step(); look(); n++; end
    chk("hl_latency", n, 4);
    chk("hl_pc_en_h", pc_en, 0); chk("hl_mem_wb_h", mem_wb_en, 0);
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); step(); look();
    chk("hl_stays", halted, 1); chk("hl_id_ex_en", id_ex_en, 0);

    // FWD_EN=0 instance: RAW on ADD r1 stalls SUB for three cycles
    rst = 1'b0; step(); rst = 1'b1;
    set_id(1, 2, 1, 3, 1, 1, 1, 0, 0); step();
    set_id(1, 1, 1, 1, 1, 4, 1, 0, 0); n = 0; look();
    while (!d0_pc_en && n < 8) begin
      n++;
      chk("f0_id_ex_fl", d0_id_ex_flush, 1);
      step(); look();
    end
    chk("f0_stall_cycles", n, 3);
    step(); nop(); look();
    chk("f0_fwd_a", d0_fwd_a_sel, 0); chk("f0_fwd_b", d0_fwd_b_sel, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
